// File: rtl/ram_bus_master.sv
// ram_bus_master: valid/ready request port to sequenced tri-state RAM bus cycles,
// with single-word writes, pipelined burst reads and a turnaround after reads.
module ram_bus_master #(
    parameter int BitCount  = 16,
    parameter int AddrWidth = 8,
    parameter int LenWidth  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [LenWidth-1:0]  req_len,
    input  logic [BitCount-1:0]  req_wdata,
    output logic                 rsp_valid,
    output logic [BitCount-1:0]  rsp_rdata,
    output logic                 wr_done,
    output logic                 busy,
    output logic                 ram_st,
    output logic                 ram_oe,
    output logic [AddrWidth-1:0] ram_addr,
    inout  wire  [BitCount-1:0]  ram_data
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_FILL, RD_STREAM, TURN} state_t;
    state_t state, next;
    logic [BitCount-1:0] wdata;
    logic [LenWidth:0]   len_n, issued, captured;
    logic                accept, last_cap;
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
    assign last_cap  = captured + 1'b1 == len_n;
    assign ram_data  = ram_st ? wdata : 'z;
    always_comb begin
        next = state;
        unique case (state)
            IDLE:      next = accept ? (req_we ? WRITE : RD_FILL) : IDLE;
            WRITE:     next = IDLE;
            RD_FILL:   next = RD_STREAM;
            RD_STREAM: next = last_cap ? TURN : RD_STREAM;
            TURN:      next = IDLE;
            default:   next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ram_st    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
            wdata     <= '0;
            len_n     <= '0;
            issued    <= '0;
            captured  <= '0;
        end else begin
            state     <= next;
            ram_st    <= next == WRITE;
            ram_oe    <= next == RD_STREAM;
            wr_done   <= state == WRITE;
            rsp_valid <= state == RD_STREAM;
            if (state == RD_STREAM) begin
                rsp_rdata <= ram_data;
                captured  <= captured + 1'b1;
            end
            // Address A is issued at acceptance; later beats issue one per edge until N are out.
            if (accept) begin
                ram_addr <= req_addr;
                wdata    <= req_wdata;
                len_n    <= (LenWidth+1)'(req_len) + 1'b1;
                issued   <= (LenWidth+1)'(1);
                captured <= '0;
            end else if ((state == RD_FILL || state == RD_STREAM) && issued < len_n) begin
                ram_addr <= ram_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
        end
    end
endmodule
